// File: rtl/diff.sv
// ============================================================================
//  Module   : diff
//  Purpose  : Registered locator of the lowest bit where A and B differ,
//             with an equality flag (miniRISC "diff" instruction).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module diff #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [IDX_W-1:0] out,
    output logic             eq
);

    localparam logic [IDX_W-1:0] c_idx_zero = '0;

    logic [WIDTH-1:0] w_x;
    logic [IDX_W-1:0] w_idx;
    logic             w_eqc;

    logic             r_out_valid;
    logic [IDX_W-1:0] r_out;
    logic             r_eq;

    assign w_x   = A ^ B;
    assign w_eqc = (w_x == '0);

    // Scan from the top down so the lowest set bit is the last to win.
    // An all-zero pattern leaves the index at zero.
    always_comb begin
        w_idx = c_idx_zero;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_x[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= c_idx_zero;
            r_eq        <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_idx;
                r_eq  <= w_eqc;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign eq        = r_eq;

endmodule

`default_nettype wire

// File: tb/tb_diff.sv
// ============================================================================
//  Module   : tb_diff
//  Purpose  : Self-checking bench for diff against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_diff;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic [IDX_W-1:0] out;
    logic             eq;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: what the registered outputs should currently show.
    logic      m_ov  = 1'b0;
    int        m_out = 0;
    logic      m_eq  = 1'b0;

    diff #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out      (out),
        .eq       (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lowest differing position: isolate the lowest set bit of A^B with
    // two's-complement arithmetic, then find which power of two it is.
    function automatic int lowest_diff(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] lowbit;
        x = a ^ b;
        if (x == 32'd0) return 0;
        lowbit = x & (~x + 32'd1);
        for (int k = 0; k < 32; k++) begin
            if (lowbit == (32'd1 << k)) return k;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, let the edge happen, update the model,
    // then compare all three outputs.
    task automatic step(input logic r, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
        @(negedge clk);
        rst = r; in_valid = v; A = a; B = b;
        @(posedge clk);
        #1;
        if (r) begin
            m_ov = 1'b0; m_out = 0; m_eq = 1'b0;
        end else begin
            m_ov = v;
            if (v) begin
                m_out = lowest_diff(a, b);
                m_eq  = (a == b);
            end
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, ".out"},       32'(out),       32'(m_out));
        check({tag, ".eq"},        32'(eq),        32'(m_eq));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;

        step(1'b1, 1'b1, 32'd5, 32'd9, "reset");
        check("reset.out_const", 32'(out), 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, "idle");

        step(1'b0, 1'b1, 32'd126, 32'd2, "t1");
        check("t1.const", 32'(out), 32'd2);
        step(1'b0, 1'b1, 32'd4, 32'd12, "t2");
        check("t2.const", 32'(out), 32'd3);
        step(1'b0, 1'b1, 32'd0, 32'd0, "eq_zero");
        check("eq_zero.const", 32'(eq), 32'd1);
        step(1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, "eq_dead");
        step(1'b0, 1'b1, 32'h80000000, 32'd0, "msb");
        check("msb.const", 32'(out), 32'd31);
        step(1'b0, 1'b1, 32'd1, 32'd0, "lsb");
        step(1'b0, 1'b1, 32'hFFFFFFFF, 32'd0, "all_ones");

        // Back-to-back, then an idle cycle with junk operands must hold.
        step(1'b0, 1'b1, 32'd126, 32'd2, "b2b0");
        step(1'b0, 1'b1, 32'd4, 32'd12, "b2b1");
        step(1'b0, 1'b1, 32'd7, 32'd7, "b2b2");
        step(1'b0, 1'b0, 32'd1, 32'd0, "hold");
        check("hold.eq_const", 32'(eq), 32'd1);

        // Reset wins over a valid pair; first result one cycle after release.
        step(1'b0, 1'b1, 32'd4, 32'd12, "pre_rst");
        step(1'b1, 1'b1, 32'd4, 32'd12, "rst_valid");
        step(1'b0, 1'b0, 32'd4, 32'd12, "rst_rel");
        step(1'b0, 1'b1, 32'd4, 32'd12, "post_rst");

        // Random pairs with sparse XOR patterns, swaps, and idle gaps.
        for (int n = 0; n < 200; n++) begin
            ra = $urandom;
            rb = ra ^ ($urandom << $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) rb = ra;
            step(1'b0, ($urandom_range(0, 3) != 0), ra, rb, "rand");
            if (n % 7 == 0) step(1'b0, 1'b1, rb, ra, "swap");
            if (n % 50 == 49) step(1'b1, 1'b1, ra, rb, "rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
